avalon_slave_fsm: RTL and testbench
===================================

Name: avalon_slave_fsm

Overview:
Avalon-MM memory-mapped slave that holds the configuration and handshake registers of the Sobel edge-detection accelerator. It stores a start pixel address, an end pixel address, a 1-bit run control and a 1-bit status flag. A small FSM sequences control and status. It sits between the Avalon interconnect (host/NIOS side) and the Sobel datapath, which consumes startpixel, endpixel, control and status.

Parameters:
ADDR_W, 32, width of the address input (word index, not byte address)
DATA_W, 32, width of writedata/readdata/startpixel/endpixel

Ports:
clk  input  1  system clock; all state updates on rising edge
n_rst  input  1  reset; one clock; reset is synchronous and active-high (asserted = 1, sampled on rising edge of clk)
write  input  1  Avalon write strobe, single-cycle, no waitrequest
read  input  1  Avalon read strobe, single-cycle, no waitrequest
address  input  ADDR_W  register word index
writedata  input  DATA_W  write data
readdata  output  DATA_W  registered read data
startpixel  output  DATA_W  start pixel address register
endpixel  output  DATA_W  end pixel address register
control  output  1  run/enable bit to datapath
status  output  1  host-acknowledged-run flag

Behaviour:
- Register map (word index): 0 reserved (read 0, writes ignored); 1 startpixel RW; 2 endpixel RW; 3 status RO (writes ignored); 4 control RW (bit 0 only, bits 31:1 ignored, read as 0); all other addresses read 0, writes ignored.
- All outputs registered. Reset (n_rst=1 at rising edge) sets readdata, startpixel, endpixel, control and status to 0, and FSM to IDLE. Reset takes priority over any concurrent read/write.
- Write: with write=1 at a rising edge, the addressed register takes writedata on that edge and is visible on its output immediately after. Latency is 1 cycle. Back-to-back writes every cycle are allowed.
- Read: with read=1 at a rising edge, readdata takes the addressed value on that edge. The value is zero-extended for the 1-bit registers. Latency is 1 cycle, no waitrequest. In any cycle with read=0, readdata is loaded with 0.
- Simultaneous read and write: both are performed. readdata returns the pre-write value of the addressed register.
- FSM, 3 states, encoding in the shared package:
  - IDLE: control=0, status=0. A write to addr 4 with writedata[0]=1 goes to ARMED.
  - ARMED: control=1, status=0. A read of addr 3 goes to ACKED, and that read returns 1 (the next-state status value). A write to addr 4 with bit0=0 goes to IDLE. A write to addr 4 with bit0=1 stays in ARMED.
  - ACKED: control=1, status=1. A write to addr 4 with bit0=0 goes to IDLE, clearing control and status on the same edge. Further reads of addr 3 return 1. A write to addr 4 with bit0=1 stays in ACKED.
- A read of addr 3 in IDLE returns 0 and causes no transition.
- control and status are decoded directly from the FSM state register (no separate flops).
- startpixel and endpixel are independent of FSM state. Both remain writable in every state and retain their values across control toggles; only reset clears them.
- No range or ordering check between startpixel and endpixel.

Decomposition:
- Shared package avalon_slave_pkg holds:
  - register index constants ADDR_STARTPIXEL=1, ADDR_ENDPIXEL=2, ADDR_STATUS=3, ADDR_CONTROL=4;
  - enum state_t {IDLE, ARMED, ACKED}.
- One sub-module is natural: avalon_slave_ctrl_fsm, containing the state register, next-state logic and the control/status decode. The top holds the data registers and the read mux.

Test Plan:
- Hold n_rst=1 for 2 cycles -> readdata, startpixel, endpixel, control, status all 0.
- Release reset; write addr 1 data 4444 -> after 1 edge startpixel=4444, all others 0, readdata=0.
- Write addr 2 data 6666 -> endpixel=6666, startpixel still 4444, control=0, status=0.
- Write addr 4 data 1, then repeat the same write -> control=1, status=0 both times, pixels unchanged, readdata=0.
- Read addr 3 -> next edge readdata=1, status=1, control=1, startpixel=4444, endpixel=6666. Then read addr 1 -> readdata=4444. Then write addr 4 data 0 -> control=0, status=0, pixels retained.
- Boundary cases:
  - write addr 3 or addr 7 -> no register changes;
  - read addr 0 or addr 9 -> readdata=0;
  - simultaneous write/read addr 1 (data 5) -> readdata=old value, startpixel=5;
  - reset asserted while in ACKED -> all outputs 0 on next edge.

Source files
------------

// File: rtl/avalon_slave_pkg.sv
// Shared definitions for the Sobel accelerator's Avalon-MM register slave.
// Holds the register word indices and the control FSM state encoding.
// Imported by the control FSM and the top-level register block.
package avalon_slave_pkg;

  localparam int ADDR_STARTPIXEL = 1;
  localparam int ADDR_ENDPIXEL   = 2;
  localparam int ADDR_STATUS     = 3;
  localparam int ADDR_CONTROL    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACKED = 2'd2
  } state_t;

endpackage

// File: rtl/avalon_slave_fsm_if.sv
// Avalon-MM bus bundle between the interconnect (master) and the register slave.
// Single-cycle read/write strobes, no waitrequest; readdata is registered in the slave.
// The master drives strobes, address and writedata; the slave drives readdata.
interface avalon_slave_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  write, read, address, writedata,
    output readdata
  );

endinterface

// File: rtl/avalon_slave_ctrl_fsm.sv
// Run/acknowledge sequencer: IDLE -> ARMED on run=1, ARMED -> ACKED on status read.
// State updates one edge after the triggering strobe; control/status decode the state register.
// No backpressure: every strobe is accepted in the cycle it is presented.
module avalon_slave_ctrl_fsm (
  input  logic clk,
  input  logic n_rst,
  input  logic ctrl_wr,
  input  logic ctrl_bit,
  input  logic status_rd,
  output logic control,
  output logic status,
  output logic status_next
);

  import avalon_slave_pkg::*;

  state_t state;
  state_t state_nxt;

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a control write always wins over a status read (they target different words).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_wr && ctrl_bit) state_nxt = ARMED;
      end
      ARMED: begin
        if (ctrl_wr) begin
          state_nxt = ctrl_bit ? ARMED : IDLE;
        end else if (status_rd) begin
          state_nxt = ACKED;
        end
      end
      ACKED: begin
        if (ctrl_wr && !ctrl_bit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign control     = (state != IDLE);
  assign status      = (state == ACKED);
  // A status read returns the value status takes on the same edge, so ARMED reads back 1.
  assign status_next = (state_nxt == ACKED);

endmodule

// File: rtl/avalon_slave_fsm.sv
// Avalon-MM slave holding Sobel start/end pixel addresses plus run control and status.
// Writes visible 1 cycle after the strobe edge; readdata registered, 1 cycle latency.
// No waitrequest: back-to-back reads/writes accepted every cycle.
module avalon_slave_fsm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  avalon_slave_fsm_if.slave bus,
  output logic [DATA_W-1:0] startpixel,
  output logic [DATA_W-1:0] endpixel,
  output logic              control,
  output logic              status
);

  import avalon_slave_pkg::*;

  logic              hit_start;
  logic              hit_end;
  logic              hit_status;
  logic              hit_control;
  logic              status_next;
  logic [DATA_W-1:0] rd_val;

  assign hit_start   = (bus.address == ADDR_W'(ADDR_STARTPIXEL));
  assign hit_end     = (bus.address == ADDR_W'(ADDR_ENDPIXEL));
  assign hit_status  = (bus.address == ADDR_W'(ADDR_STATUS));
  assign hit_control = (bus.address == ADDR_W'(ADDR_CONTROL));

  avalon_slave_ctrl_fsm u_ctrl_fsm (
    .clk         (clk),
    .n_rst       (n_rst),
    .ctrl_wr     (bus.write && hit_control),
    .ctrl_bit    (bus.writedata[0]),
    .status_rd   (bus.read && hit_status),
    .control     (control),
    .status      (status),
    .status_next (status_next)
  );

  // Read mux: pixel/control words return pre-write values; status returns its post-edge value.
  always_comb begin
    rd_val = '0;
    if (hit_start) begin
      rd_val = startpixel;
    end else if (hit_end) begin
      rd_val = endpixel;
    end else if (hit_status) begin
      rd_val = {{(DATA_W-1){1'b0}}, status_next};
    end else if (hit_control) begin
      rd_val = {{(DATA_W-1){1'b0}}, control};
    end
  end

  // Pixel registers and registered readdata; reset overrides any concurrent access.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      startpixel   <= '0;
      endpixel     <= '0;
      bus.readdata <= '0;
    end else begin
      if (bus.write && hit_start) startpixel <= bus.writedata;
      if (bus.write && hit_end)   endpixel   <= bus.writedata;
      bus.readdata <= bus.read ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_avalon_slave_fsm.sv
// Self-checking bench: directed register-map walk then randomized traffic vs. a behavioural model.
// Inputs driven on the falling edge; outputs compared on the following falling edge.
// Model tracks run/acknowledged flags and pixel words directly from the register rules.
module tb_avalon_slave_fsm;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] startpixel;
  logic [31:0] endpixel;
  logic        control;
  logic        status;

  always #5 clk = ~clk;

  avalon_slave_fsm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  avalon_slave_fsm #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus.slave),
    .startpixel (startpixel),
    .endpixel   (endpixel),
    .control    (control),
    .status     (status)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_sp, m_ep, m_rd;
  bit          m_run, m_ack;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit wr, input bit rd,
                            input logic [31:0] addr, input logic [31:0] wd);
    if (rst) begin
      m_sp = '0; m_ep = '0; m_rd = '0; m_run = 0; m_ack = 0;
    end else begin
      m_rd = '0;
      if (rd) begin
        case (addr)
          32'd1:   m_rd = m_sp;
          32'd2:   m_rd = m_ep;
          32'd3:   m_rd = {31'd0, m_run};
          32'd4:   m_rd = {31'd0, m_run};
          default: m_rd = '0;
        endcase
        if (addr == 32'd3 && m_run) m_ack = 1;
      end
      if (wr) begin
        case (addr)
          32'd1: m_sp = wd;
          32'd2: m_ep = wd;
          32'd4: begin
            if (wd[0]) begin
              m_run = 1;
            end else begin
              m_run = 0;
              m_ack = 0;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit wr, input bit rd,
                       input logic [31:0] addr, input logic [31:0] wd);
    n_rst         = rst;
    bus.write     = wr;
    bus.read      = rd;
    bus.address   = addr;
    bus.writedata = wd;
    @(posedge clk);
    model_step(rst, wr, rd, addr, wd);
    @(negedge clk);
    check_val("readdata",   bus.readdata, m_rd);
    check_val("startpixel", startpixel,   m_sp);
    check_val("endpixel",   endpixel,     m_ep);
    check_val("control",    {31'd0, control}, {31'd0, m_run});
    check_val("status",     {31'd0, status},  {31'd0, m_ack});
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    bit          w, r, rs;

    n_rst = 1'b1; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    m_sp = '0; m_ep = '0; m_rd = '0; m_run = 0; m_ack = 0;
    @(negedge clk);

    // Reset for two cycles
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_val("rst_readdata", bus.readdata, 32'd0);

    // Pixel writes
    cycle(0, 1, 0, 1, 32'd4444);
    check_val("plan_sp", startpixel, 32'd4444);
    cycle(0, 1, 0, 2, 32'd6666);
    check_val("plan_ep", endpixel, 32'd6666);

    // Arm twice
    cycle(0, 1, 0, 4, 1);
    cycle(0, 1, 0, 4, 1);
    check_val("plan_ctrl_armed", {31'd0, control}, 32'd1);
    check_val("plan_stat_armed", {31'd0, status},  32'd0);

    // Acknowledge via status read
    cycle(0, 0, 1, 3, 0);
    check_val("plan_rd_status", bus.readdata, 32'd1);
    check_val("plan_stat_acked", {31'd0, status}, 32'd1);
    cycle(0, 0, 1, 3, 0);
    check_val("plan_rd_status2", bus.readdata, 32'd1);
    cycle(0, 0, 1, 1, 0);
    check_val("plan_rd_sp", bus.readdata, 32'd4444);
    cycle(0, 0, 1, 4, 0);
    check_val("plan_rd_ctrl", bus.readdata, 32'd1);

    // Disarm
    cycle(0, 1, 0, 4, 0);
    check_val("plan_ctrl_off", {31'd0, control}, 32'd0);
    check_val("plan_stat_off", {31'd0, status},  32'd0);

    // Status read while idle: 0, no transition
    cycle(0, 0, 1, 3, 0);
    check_val("idle_rd_status", bus.readdata, 32'd0);

    // Writes to read-only / unmapped words; reads of reserved / unmapped words
    cycle(0, 1, 0, 3, 32'hFFFF_FFFF);
    cycle(0, 1, 0, 7, 32'h1234_5678);
    cycle(0, 1, 0, 0, 32'hDEAD_BEEF);
    cycle(0, 0, 1, 0, 0);
    check_val("rd_addr0", bus.readdata, 32'd0);
    cycle(0, 0, 1, 9, 0);
    check_val("rd_addr9", bus.readdata, 32'd0);

    // Control bits above bit 0 ignored and read as zero
    cycle(0, 1, 0, 4, 32'hFFFF_FFFE);
    check_val("ctrl_bit1_only", {31'd0, control}, 32'd0);
    cycle(0, 1, 1, 4, 32'hFFFF_FFFF);
    check_val("ctrl_rw_old", bus.readdata, 32'd0);

    // Simultaneous read/write returns the old value
    cycle(0, 1, 1, 1, 32'd5);
    check_val("rw_old_value", bus.readdata, 32'd4444);
    check_val("rw_new_sp", startpixel, 32'd5);

    // Reset while acknowledged, with a concurrent access
    cycle(0, 0, 1, 3, 0);
    check_val("pre_rst_status", {31'd0, status}, 32'd1);
    cycle(1, 1, 1, 1, 32'd123);
    check_val("rst_acked_sp",   startpixel, 32'd0);
    check_val("rst_acked_ctrl", {31'd0, control}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 99) == 0);
      w  = $urandom_range(0, 1);
      r  = $urandom_range(0, 1);
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 9));
      d  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      cycle(rs, w, r, a, d);
    end

    n_rst = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
